// File: rtl/add_pipe_cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// group width, operation encoding and the 4-bit lookahead equations.
package add_pipe_cla_pkg;

  // Width of one lookahead group; every pipeline stage resolves one group.
  localparam int GROUP_W = 4;

  // Operation selected by the 'sub' input.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Bitwise generate/propagate terms of one group.
  typedef struct packed {
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
  } gp_t;

  // Generate/propagate for one group of operand bits.
  function automatic gp_t group_gp(input logic [GROUP_W-1:0] a,
                                   input logic [GROUP_W-1:0] b);
    gp_t r;
    r.g = a & b;
    r.p = a ^ b;
    return r;
  endfunction

  // Flattened lookahead: carries into bits 1..4 of the group from c0,
  // each one a two-level AND-OR of g/p rather than a ripple.
  function automatic logic [GROUP_W:1] lookahead(input gp_t gp, input logic c0);
    logic [GROUP_W:1] c;
    c[1] = gp.g[0] | (gp.p[0] & c0);
    c[2] = gp.g[1] | (gp.p[1] & gp.g[0]) | (gp.p[1] & gp.p[0] & c0);
    c[3] = gp.g[2] | (gp.p[2] & gp.g[1]) | (gp.p[2] & gp.p[1] & gp.g[0])
         | (gp.p[2] & gp.p[1] & gp.p[0] & c0);
    c[4] = gp.g[3] | (gp.p[3] & gp.g[2]) | (gp.p[3] & gp.p[2] & gp.g[1])
         | (gp.p[3] & gp.p[2] & gp.p[1] & gp.g[0])
         | (gp.p[3] & gp.p[2] & gp.p[1] & gp.p[0] & c0);
    return c;
  endfunction

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead group: sum slice, group carry-out and
// the carry into its top bit (needed for signed overflow at the MSB group).
module cla4_group
  import add_pipe_cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               c_in,
  output logic [GROUP_W-1:0] s,
  output logic               c_out,
  output logic               c3
);

  gp_t              gp;
  logic [GROUP_W:1] c;

  assign gp    = group_gp(a, b);
  assign c     = lookahead(gp, c_in);
  assign s     = gp.p ^ {c[3:1], c_in};
  assign c_out = c[4];
  assign c3    = c[3];

endmodule

// File: rtl/add_pipe_cla.sv
// Pipelined carry-lookahead adder/subtractor. One 4-bit group per stage; the
// group carry is registered and consumed by the next stage one cycle later.
// Operand slices above the current group are skewed through per-stage shift
// registers, and finished sum slices travel forward with the beat so the whole
// result leaves the last stage together. The last stage register is the output
// register. WIDTH must be a multiple of 4 and at least 4.
module add_pipe_cla
  import add_pipe_cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP_W;

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             adv;
  logic             acc;

  // Subtraction is a + ~b + 1; cin only matters when adding.
  assign op    = op_e'(sub);
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c0    = (op == OP_SUB) ? 1'b1 : cin;

  // The whole pipe moves as one: it advances whenever the output slot is
  // empty or being drained, otherwise every stage holds.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign acc      = in_valid & adv;

  for (genvar k = 0; k < NG; k++) begin : stg
    logic                       vld_q;
    logic [GROUP_W*(k+1)-1:0]   sum_q;
    logic                       c_q;

    logic                       vld_d;
    logic [GROUP_W*(k+1)-1:0]   sum_d;
    logic [GROUP_W-1:0]         ga;
    logic [GROUP_W-1:0]         gb;
    logic [GROUP_W-1:0]         gs;
    logic                       gc_in;
    logic                       gc_out;
    logic                       gc3;

    if (k == 0) begin : g_first
      // First group works straight off the accepted operands.
      assign ga    = a[GROUP_W-1:0];
      assign gb    = b_eff[GROUP_W-1:0];
      assign gc_in = c0;
      assign vld_d = acc;
      assign sum_d = gs;
    end else begin : g_next
      // Later groups take their skewed slice and the previous stage's carry,
      // and append their slice above the sum bits already resolved.
      assign ga    = stg[k-1].g_skew.opa_q[GROUP_W-1:0];
      assign gb    = stg[k-1].g_skew.opb_q[GROUP_W-1:0];
      assign gc_in = stg[k-1].c_q;
      assign vld_d = stg[k-1].vld_q;
      assign sum_d = {gs, stg[k-1].sum_q};
    end

    cla4_group u_grp (
      .a    (ga),
      .b    (gb),
      .c_in (gc_in),
      .s    (gs),
      .c_out(gc_out),
      .c3   (gc3)
    );

    // Stage register: valid, resolved sum bits and the group carry.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the pipe shifts cleanly.
    // NOTE: data registers are reset as well as valids, so s/cout/ovf are
    // never X after reset even though invalid data is don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (adv) begin
        vld_q <= vld_d;
        sum_q <= sum_d;
        c_q   <= gc_out;
      end
    end

    if (k < NG - 1) begin : g_skew
      // Operand slices not yet consumed, lowest pending slice at bit 0.
      logic [WIDTH-GROUP_W*(k+1)-1:0] opa_q;
      logic [WIDTH-GROUP_W*(k+1)-1:0] opb_q;
      logic [WIDTH-GROUP_W*(k+1)-1:0] opa_d;
      logic [WIDTH-GROUP_W*(k+1)-1:0] opb_d;
      logic                           unused_c3;

      if (k == 0) begin : g_src_in
        assign opa_d = a[WIDTH-1:GROUP_W];
        assign opb_d = b_eff[WIDTH-1:GROUP_W];
      end else begin : g_src_prev
        assign opa_d = stg[k-1].g_skew.opa_q[WIDTH-GROUP_W*k-1:GROUP_W];
        assign opb_d = stg[k-1].g_skew.opb_q[WIDTH-GROUP_W*k-1:GROUP_W];
      end

      // Only the MSB group's internal carry feeds overflow.
      assign unused_c3 = gc3;

      // Skew register: upper operand slices wait here for their group.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (adv) begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= gc_out ^ gc3;
        end
      end
    end
  end

  assign out_valid = stg[NG-1].vld_q;
  assign s         = stg[NG-1].sum_q;
  assign cout      = stg[NG-1].c_q;
  assign ovf       = stg[NG-1].g_last.ovf_q;

endmodule

// File: tb/tb_add_pipe_cla.sv
// Self-checking bench for add_pipe_cla: a 16-bit instance for directed,
// backpressure, reset and random streams, and a 4-bit instance swept
// exhaustively under random out_ready. Expected results come from a
// behavioural arithmetic model pushed to per-instance scoreboards on accept.
module tb_add_pipe_cla;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 16-bit instance
  logic        v16, r16, ov16, or16, cin16, sub16, cout16, ovf16;
  logic [15:0] a16, b16, s16;

  // 4-bit instance
  logic        v4, r4, ov4, or4, cin4, sub4, cout4, ovf4;
  logic [3:0]  a4, b4, s4;

  add_pipe_cla #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v16), .in_ready(r16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16), .s(s16), .cout(cout16), .ovf(ovf16)
  );

  add_pipe_cla #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .in_ready(r4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(ov4), .out_ready(or4), .s(s4), .cout(cout4), .ovf(ovf4)
  );

  int vectors     = 0;
  int miscompares = 0;
  int pops16      = 0;
  int pops4       = 0;

  logic [17:0] q16[$];   // {cout, ovf, s}
  logic [5:0]  q4[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: returns {cout, ovf, s} with s masked to w bits.
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin,
                                        input logic sub);
    logic [31:0] mask, bb, r;
    logic [32:0] full;
    logic        c0, co, ov;
    mask = 32'((64'd1 << w) - 64'd1);
    bb   = sub ? (~b & mask) : (b & mask);
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, a & mask} + {1'b0, bb} + {32'd0, c0};
    co   = full[w];
    r    = full[31:0] & mask;
    ov   = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
    return {co, ov, r};
  endfunction

  // Scoreboard: push on accept, pop and compare on emit, both sampled mid-cycle.
  always @(negedge clk) begin : mon
    logic [33:0] m;
    logic [17:0] e16;
    logic [5:0]  e4;
    if (rst_n) begin
      if (ov16 && or16) begin
        if (q16.size() == 0) check("x16_unexpected_out", 32'd1, 32'd0);
        else begin
          e16 = q16.pop_front();
          pops16++;
          check("x16_s",    32'(s16),    32'(e16[15:0]));
          check("x16_cout", 32'(cout16), 32'(e16[17]));
          check("x16_ovf",  32'(ovf16),  32'(e16[16]));
        end
      end
      if (v16 && r16) begin
        m = model(16, 32'(a16), 32'(b16), cin16, sub16);
        q16.push_back({m[33], m[32], m[15:0]});
      end
      if (ov4 && or4) begin
        if (q4.size() == 0) check("x4_unexpected_out", 32'd1, 32'd0);
        else begin
          e4 = q4.pop_front();
          pops4++;
          check("x4_s",    32'(s4),    32'(e4[3:0]));
          check("x4_cout", 32'(cout4), 32'(e4[5]));
          check("x4_ovf",  32'(ovf4),  32'(e4[4]));
        end
      end
      if (v4 && r4) begin
        m = model(4, 32'(a4), 32'(b4), cin4, sub4);
        q4.push_back({m[33], m[32], m[3:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat on the 16-bit instance, checked against constants and
  // for exact latency (4 cycles from the accepting edge).
  task automatic single_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub, input logic [15:0] es,
                             input logic ec, input logic eo);
    int n;
    or16 = 1'b1; v16 = 1'b1; a16 = a; b16 = b; cin16 = cin; sub16 = sub;
    tick();
    v16 = 1'b0;
    n = 1;
    while (!ov16 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_s"},    32'(s16),    32'(es));
    check({tag, "_cout"}, 32'(cout16), 32'(ec));
    check({tag, "_ovf"},  32'(ovf16),  32'(eo));
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q16.size() != 0 || q4.size() != 0); i++) tick();
    check("drain16_empty", 32'(q16.size()), 32'd0);
    check("drain4_empty",  32'(q4.size()),  32'd0);
  endtask

  initial begin
    int idx, p0;
    logic acc;
    rst_n = 1'b0;
    v16 = 0; or16 = 1; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0;
    v4  = 0; or4  = 1; a4  = '0; b4  = '0; cin4  = 0; sub4  = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(ov16),   32'd0);
    check("rst_s",         32'(s16),    32'h0000);
    check("rst_cout",      32'(cout16), 32'd0);
    check("rst_ovf",       32'(ovf16),  32'd0);
    check("rst_in_ready",  32'(r16),    32'd1);
    check("rst_out_valid4", 32'(ov4),   32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Directed add/sub including wrap and overflow corners
    single_beat("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single_beat("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single_beat("sub_borrow",16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single_beat("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    single_beat("sub_zero",  16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    single_beat("add_cin",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: 10 beats a=b=i, out_ready low during cycles 5..7
    idx = 0;
    p0  = pops16;
    for (int c = 0; c < 30; c++) begin
      or16  = !(c >= 5 && c <= 7);
      v16   = (idx < 10);
      a16   = 16'(idx);
      b16   = 16'(idx);
      cin16 = 1'b0;
      sub16 = 1'b0;
      @(negedge clk);
      if (c >= 5 && c <= 7) begin
        check("bp_in_ready",  32'(r16),  32'd0);
        check("bp_out_valid", 32'(ov16), 32'd1);
        check("bp_hold_s",    32'(s16),  32'h0002);
      end
      if (v16 && r16) idx++;
      @(posedge clk);
      #1;
    end
    v16 = 1'b0;
    or16 = 1'b1;
    check("bp_accepted", 32'(idx), 32'd10);
    check("bp_emitted",  32'(pops16 - p0), 32'd10);

    // Random stream with random valid/ready
    for (int c = 0; c < 400; c++) begin
      v16   = ($urandom_range(0, 3) != 0);
      or16  = ($urandom_range(0, 3) != 0);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = 1'($urandom_range(0, 1));
      sub16 = 1'($urandom_range(0, 1));
      tick();
    end
    v16 = 1'b0;
    or16 = 1'b1;
    drain();

    // Reset mid-stream with beats in flight and a valid output present
    for (int i = 0; i < 5; i++) begin
      v16 = 1'b1; a16 = 16'(100 + i); b16 = 16'(i); cin16 = 0; sub16 = 0;
      tick();
    end
    v16 = 1'b0;
    check("mid_pre_valid", 32'(ov16), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(ov16), 32'd0);
    check("mid_rst_s",         32'(s16),  32'h0000);
    q16.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    single_beat("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Exhaustive WIDTH=4 sweep under random out_ready
    p0 = pops4;
    for (int sb = 0; sb < 2; sb++)
      for (int ci = 0; ci < 2; ci++)
        for (int ia = 0; ia < 16; ia++)
          for (int ib = 0; ib < 16; ib++) begin
            int guard;
            v4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ci); sub4 = 1'(sb);
            guard = 0;
            do begin
              or4 = ($urandom_range(0, 3) != 0);
              @(negedge clk);
              acc = r4;
              @(posedge clk);
              #1;
              guard++;
            end while (!acc && guard < 50);
            if (!acc) check("x4_accept_timeout", 32'd0, 32'd1);
          end
    v4 = 1'b0;
    or4 = 1'b1;
    drain();
    check("x4_emitted", 32'(pops4 - p0), 32'd1024);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
